// File: rtl/roll_ctrl.sv
// roll_ctrl -- dice-roll game controller.
// Sequences one roll per start request (IDLE -> ARM -> ROLL -> SHOW), captures
// the roller's settled value, and keeps the running total, roll count and
// the sticky error/timeout flags.
// Optional feature: define ROLL_HISTORY_EN to keep the last four results on
// the history port (newest in [2:0]); otherwise history reads as zero and no
// history registers are built.
module roll_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned MAX_ROLLS      = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        clear,
    input  logic        choose,
    input  logic [2:0]  num,
    output logic        enable,
    output logic [2:0]  result,
    output logic        valid,
    output logic [7:0]  total,
    output logic [3:0]  count,
    output logic        busy,
    output logic        game_over,
    output logic        err,
    output logic        timeout,
    output logic [11:0] history
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        ROLL,
        SHOW
    } state_t;

    // Last ROLL-cycle index (counter value) at which the roll is abandoned.
    localparam logic [15:0] CYC_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  ROLLS_MAX = 4'(MAX_ROLLS);

    state_t      state;
    state_t      state_next;
    logic [15:0] cyc;
    logic        first_cycle;
    logic        num_legal;
    logic        take;
    logic        reject;
    logic        expire;
    logic [8:0]  sum_wide;
    logic [7:0]  total_sat;

    // Decode what the roller is telling us during the current ROLL cycle.
    always_comb begin
        first_cycle = (cyc == '0);
        num_legal   = (num != 3'd0) && (num != 3'd7);
        take        = (state == ROLL) && !first_cycle && choose && num_legal;
        reject      = (state == ROLL) && !first_cycle && choose && !num_legal;
        // A capture (or rejection) in the final allowed cycle beats the timeout.
        expire      = (state == ROLL) && (cyc == CYC_LAST) && !take && !reject;
        sum_wide    = {1'b0, total} + {6'b0, num};
        total_sat   = sum_wide[8] ? 8'hFF : sum_wide[7:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; clear overrides everything, including a pending start.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !game_over) begin
                        state_next = ARM;
                    end
                end
                ARM:  state_next = ROLL;
                ROLL: begin
                    if (take) begin
                        state_next = SHOW;
                    end else if (reject || expire) begin
                        state_next = IDLE;
                    end
                end
                SHOW:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Registered enable/valid decoded from the next state so both are glitch-free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enable <= 1'b0;
            valid  <= 1'b0;
        end else begin
            enable <= (state_next == ROLL);
            valid  <= (state_next == SHOW);
        end
    end

    // ROLL cycle counter: zero outside ROLL, so it restarts on every entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc <= '0;
        end else if ((state == ROLL) && (state_next == ROLL)) begin
            cyc <= cyc + 16'd1;
        end else begin
            cyc <= '0;
        end
    end

    // Accumulators and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result  <= '0;
            total   <= '0;
            count   <= '0;
            err     <= 1'b0;
            timeout <= 1'b0;
        end else if (clear) begin
            result  <= '0;
            total   <= '0;
            count   <= '0;
            err     <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (take) begin
                result <= num;
                total  <= total_sat;
                count  <= count + 4'd1;
            end
            if (reject) begin
                err <= 1'b1;
            end
            if (expire) begin
                timeout <= 1'b1;
            end
        end
    end

`ifdef ROLL_HISTORY_EN
    logic [11:0] hist_q;

    // Shift register of the last four accepted results, newest at the bottom.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q <= '0;
        end else if (clear) begin
            hist_q <= '0;
        end else if (take) begin
            hist_q <= {hist_q[8:0], num};
        end
    end
`endif

    // Status outputs derived from state and count.
    always_comb begin
        busy      = (state != IDLE);
        game_over = (count == ROLLS_MAX);
`ifdef ROLL_HISTORY_EN
        history   = hist_q;
`else
        history   = '0;
`endif
    end

endmodule
